// File: rtl/regfile_multiport.sv
// Multi-port register file with x0 hardwired to zero and a post-reset clear sequencer.
// Define REGFILE_BYPASS_EN to forward the same-cycle write data onto matching read ports.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_CLEAR | zeroing reg[1..DEPTH-1] one per edge; reads 0, writes dropped
// S_READY | normal operation; combinational reads, writes on rising edge
module regfile_multiport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     ready,
  output logic                     wr_err
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH-1);
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_CLEAR;
      clr_idx <= ADDR_W'(1);
      wr_err  <= 1'b0;
    end else begin
      wr_err <= 1'b0;
      if (state == S_CLEAR) begin
        wr_err  <= wr_en;
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == LAST_IDX) state <= S_READY;
      end
    end
  end

  // Entry 0 is never written; reads of address 0 are forced to zero below.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == S_CLEAR) mem[clr_idx] <= '0;
      else if (wr_en && wr_addr != '0) mem[wr_addr] <= wr_data;
    end
  end

  assign ready = (state == S_READY);

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] val;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      val = '0;
      if (state == S_READY && addr != '0) begin
`ifdef REGFILE_BYPASS_EN
        if (wr_en && addr == wr_addr) val = wr_data;
        else val = mem[addr];
`else
        val = mem[addr];
`endif
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = val;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: default 2-port 32x32 instance and a 4-port 8x16 instance
// driven in lockstep against an array-based reference model.
module tb_regfile_multiport;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [9:0]  ra_a;
  logic [63:0] rd_a;
  logic        we_a;
  logic [4:0]  wa_a;
  logic [31:0] wd_a;
  logic        ready_a, err_a;
  logic [11:0] ra_b;
  logic [63:0] rd_b;
  logic        we_b;
  logic [2:0]  wa_b;
  logic [15:0] wd_b;
  logic        ready_b, err_b;

  regfile_multiport dut_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(ra_a), .rd_data(rd_a),
    .wr_en(we_a), .wr_addr(wa_a), .wr_data(wd_a), .ready(ready_a), .wr_err(err_a)
  );

  regfile_multiport #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(ra_b), .rd_data(rd_b),
    .wr_en(we_b), .wr_addr(wa_b), .wr_data(wd_b), .ready(ready_b), .wr_err(err_b)
  );

  typedef struct {
    logic [63:0] rda;
    logic [63:0] rdb;
    logic        rya;
    logic        ryb;
    logic        era;
    logic        erb;
  } exp_t;

  exp_t q[$];

  // Reference model: edges since reset release, stored values, pending error flags.
  logic [31:0] mem_a [32];
  logic [15:0] mem_b [8];
  int          cnt_a = 0, cnt_b = 0;
  logic        m_err_a = 1'b0, m_err_b = 1'b0;
  bit          started = 1'b0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] exp_rd_a();
    logic [63:0] r;
    logic [4:0]  ad;
    logic [31:0] v;
    r = '0;
    for (int k = 0; k < 2; k++) begin
      ad = ra_a[k*5 +: 5];
      v  = (ad == 0) ? 32'h0 : mem_a[ad];
`ifdef REGFILE_BYPASS_EN
      if (we_a && wa_a != 0 && ad == wa_a) v = wd_a;
`endif
      if (cnt_a < 31) v = '0;
      r[k*32 +: 32] = v;
    end
    return r;
  endfunction

  function automatic logic [63:0] exp_rd_b();
    logic [63:0] r;
    logic [2:0]  ad;
    logic [15:0] v;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      ad = ra_b[k*3 +: 3];
      v  = (ad == 0) ? 16'h0 : mem_b[ad];
`ifdef REGFILE_BYPASS_EN
      if (we_b && wa_b != 0 && ad == wa_b) v = wd_b;
`endif
      if (cnt_b < 7) v = '0;
      r[k*16 +: 16] = v;
    end
    return r;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      cnt_a = 0; cnt_b = 0; m_err_a = 1'b0; m_err_b = 1'b0;
      foreach (mem_a[i]) mem_a[i] = '0;
      foreach (mem_b[i]) mem_b[i] = '0;
    end else begin
      m_err_a = we_a && (cnt_a < 31);
      if (cnt_a < 31) cnt_a++;
      else if (we_a && wa_a != 0) mem_a[wa_a] = wd_a;
      m_err_b = we_b && (cnt_b < 7);
      if (cnt_b < 7) cnt_b++;
      else if (we_b && wa_b != 0) mem_b[wa_b] = wd_b;
    end
  endtask

  // Called at a falling edge with inputs already applied; returns at the next falling edge.
  task automatic step();
    exp_t e;
    #1;
    if (started) begin
      e.rda = exp_rd_a();
      e.rdb = exp_rd_b();
      e.rya = (cnt_a >= 31);
      e.ryb = (cnt_b >= 7);
      e.era = m_err_a;
      e.erb = m_err_b;
      q.push_back(e);
    end
    @(posedge clk);
    model_edge();
    started = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_inputs(input int wpct);
    we_a = ($urandom_range(0, 99) < wpct);
    wa_a = 5'($urandom);
    wd_a = $urandom;
    ra_a = 10'($urandom);
    if ($urandom_range(0, 3) == 0) ra_a[9:5] = wa_a;
    we_b = ($urandom_range(0, 99) < wpct);
    wa_b = 3'($urandom);
    wd_b = 16'($urandom);
    ra_b = 12'($urandom);
    if ($urandom_range(0, 3) == 0) ra_b[5:3] = wa_b;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rd_data_a", rd_a, e.rda);
        chk("rd_data_b", rd_b, e.rdb);
        chk("ready_a", {63'b0, ready_a}, {63'b0, e.rya});
        chk("ready_b", {63'b0, ready_b}, {63'b0, e.ryb});
        chk("wr_err_a", {63'b0, err_a}, {63'b0, e.era});
        chk("wr_err_b", {63'b0, err_b}, {63'b0, e.erb});
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    rand_inputs(0);
    @(negedge clk);
    repeat (2) begin rand_inputs(50); step(); end
    rst_n = 1'b1;

    // Clear window with dropped writes, forced on edges 3 and 4, crossing the ready edge.
    for (int i = 0; i < 40; i++) begin
      rand_inputs(30);
      if (i == 2 || i == 3) we_a = 1'b1;
      if (i == 30) begin we_a = 1'b1; we_b = 1'b1; end
      step();
    end

    rand_inputs(0);
    we_a = 1'b1; wa_a = 5'd5; wd_a = 32'hDEADBEEF;
    step();
    we_a = 1'b0; ra_a = {5'd5, 5'd5};
    step();
    we_a = 1'b1; wa_a = 5'd0; wd_a = 32'h12345678; ra_a = 10'd0;
    step();
    we_a = 1'b0;
    step();

    we_a = 1'b1; wa_a = 5'd7; wd_a = 32'hA5A5A5A5; ra_a = {5'd7, 5'd7};
    step();
    we_a = 1'b0;
    step();

    for (int i = 0; i < 400; i++) begin rand_inputs(50); step(); end

    for (int i = 1; i < 32; i++) begin
      rand_inputs(0);
      we_a = 1'b1; wa_a = 5'(i); wd_a = 32'(i);
      we_b = 1'b1; wa_b = 3'(i); wd_b = 16'(i);
      step();
    end
    rst_n = 1'b0;
    rand_inputs(50);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      rand_inputs(0);
      ra_a = {5'(i), 5'(31 - i)};
      ra_b = {3'(i), 3'(i + 1), 3'(i + 2), 3'(i + 3)};
      step();
    end

    for (int i = 0; i < 300; i++) begin rand_inputs(50); step(); end

    rand_inputs(0);
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_multiport.md
# regfile_multiport

Parametrised general-purpose register file for the RISC-V core, successor to the fixed two-read, one-write 32x32 bank. It provides a configurable width, depth and number of combinational read ports, with x0 hardwired to zero. A synchronous-reset clear sequencer zeroes every register after reset and flags writes dropped during that window. Optional same-cycle write-to-read bypass is available. It sits between the decode stage (read addresses) and the writeback stage (write port).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
- NUM_RD, 2, number of read ports (1..4)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- ready  out  1  high once the clear sequence is complete
- wr_err  out  1  one-cycle pulse: a write was dropped because ready was low

## Operation
- FSM states: CLEAR and READY.
  - rst_n low at an edge: state=CLEAR, clr_idx=1, ready=0, wr_err=0. Storage is not modified on that edge.
  - In CLEAR with rst_n high, each edge writes 0 to reg[clr_idx] and increments clr_idx.
  - When clr_idx==DEPTH-1, the edge writes 0 to reg[DEPTH-1], sets state=READY and sets ready=1.
  - READY holds until rst_n is sampled low.
- Register 0 is never stored; its reads always return 0.
- Write, READY state: at an edge with wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data. A write to address 0 is silently ignored and is not an error.
- Write, CLEAR state: at an edge with wr_en=1, the write is dropped and wr_err=1 for the next cycle. wr_err is registered and cleared on the following edge unless another write is dropped.
- Read, READY state: rd_data[k] = reg[rd_addr[k]], combinational.
- Read, CLEAR state: all rd_data ports return 0.
- All read ports are independent; identical addresses on several ports return identical data.
- Reset mid-operation, in either state: the sequence restarts from clr_idx=1 and ready drops to 0 on that edge.

## Timing
- Reset values: ready=0, wr_err=0, rd_data=0 (because state is CLEAR).
- Read latency is 0 cycles (combinational from rd_addr).
- A write is visible on rd_data in the cycle after its edge, or in the same cycle with bypass enabled (see Configuration).
- ready rises on the (DEPTH-1)th rising edge after the first edge with rst_n high. For DEPTH=32 that is edge 31.
- wr_err is asserted exactly one cycle per dropped write. Back-to-back dropped writes hold it high continuously.
- A write in the same cycle as ready rising is still dropped, because it is sampled while the state is CLEAR.

## Configuration
- Macro REGFILE_BYPASS_EN.
  - Defined: in READY, if wr_en=1, wr_addr!=0 and rd_addr[k]==wr_addr, then rd_data[k]=wr_data in that same cycle. This is combinational forwarding on every port. No bypass from address 0; no bypass in CLEAR.
  - Undefined: rd_data[k] returns the stored value; the new value appears after the edge.

## Test plan
- Reset release, defaults: after 30 edges ready=0 and all ports read 0. On edge 31 ready=1. Reads of every address return 0x00000000.
- Write then read: write 0xDEADBEEF to x5, then on the next cycle set rd_addr[0]=5 and rd_addr[1]=5 -> both return 0xDEADBEEF. Write 0x12345678 to x0 -> reading x0 returns 0 and wr_err stays 0.
- Dropped writes: wr_en=1 on edges 3 and 4 after reset release -> wr_err high for 2 cycles. After ready, reading that address returns 0.
- Mid-operation reset: fill x1..x31 with their index, pull rst_n low for 1 edge -> ready=0 immediately. After 31 further edges ready=1 and all registers read 0.
- Bypass: write 0xA5A5A5A5 to x7 while rd_addr[1]=7 in the same cycle -> with REGFILE_BYPASS_EN rd_data[1]=0xA5A5A5A5 that cycle. Without it the old value is returned that cycle and 0xA5A5A5A5 the next.
- Parameter sweep: NUM_RD=4, ADDR_W=3, DATA_W=16 -> ready after 7 edges. Four ports reading distinct addresses each return their own 16-bit values.
